// File: rtl/au_seq.sv
// au_seq: sequential add/sub/mul/div unit with operand regs A/B, edge-triggered LoadA/LoadB/Start, 2*WIDTH result, Cout/OVR/DivZero flags, Busy/Done handshake
module au_seq #(
  parameter int WIDTH = 8,
  localparam int CNTW = $clog2(WIDTH) + 1
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               LoadA,
  input  logic               LoadB,
  input  logic               Start,
  input  logic [1:0]         OP,
  input  logic [WIDTH-1:0]   BIT_Input,
  output logic [WIDTH-1:0]   A_OUT,
  output logic [WIDTH-1:0]   B_OUT,
  output logic [2*WIDTH-1:0] result,
  output logic               Cout,
  output logic               OVR,
  output logic               DivZero,
  output logic               Busy,
  output logic               Done
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, ALU, ITER, FIN} state_t;
  state_t               state_q;
  logic                 la_q, lb_q, st_q;
  logic [WIDTH-1:0]     a_q, b_q, wa_q, wb_q;
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   prod_q, result_q;
  logic [CNTW-1:0]      cnt_q;
  logic                 cout_q, ovr_q, divz_q, busy_q, done_q;
  logic                 la_ev, lb_ev, st_ev, ge_d;
  logic [WIDTH:0]       as_d, ms_d, dr_d;
  logic [WIDTH-1:0]     rs_d;
  logic [2*WIDTH-1:0]   mul_d, div_d;
  assign la_ev = LoadA & ~la_q;
  assign lb_ev = LoadB & ~lb_q;
  assign st_ev = Start & ~st_q;
  assign as_d  = {1'b0, wa_q} + {1'b0, op_q[0] ? ~wb_q : wb_q} + {{WIDTH{1'b0}}, op_q[0]};
  assign ms_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? wa_q : {WIDTH{1'b0}}};
  assign mul_d = {ms_d, prod_q[WIDTH-1:1]};
  assign dr_d  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign ge_d  = dr_d >= {1'b0, wb_q};
  assign rs_d  = ge_d ? dr_d[WIDTH-1:0] - wb_q : dr_d[WIDTH-1:0];
  assign div_d = {rs_d, prod_q[WIDTH-2:0], ge_d};
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      la_q     <= 1'b0;
      lb_q     <= 1'b0;
      st_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      la_q   <= LoadA;
      lb_q   <= LoadB;
      st_q   <= Start;
      done_q <= 1'b0;
      if (!busy_q && la_ev) a_q <= BIT_Input;
      if (!busy_q && lb_ev) b_q <= BIT_Input;
      case (state_q)
        IDLE: if (st_ev) begin
          op_q    <= OP;
          wa_q    <= a_q;
          wb_q    <= b_q;
          cnt_q   <= CNTW'(WIDTH - 1);
          prod_q  <= {{WIDTH{1'b0}}, OP[0] ? a_q : b_q};
          busy_q  <= 1'b1;
          state_q <= OP[1] ? ITER : ALU;
        end
        ALU: begin
          if (!op_q[1]) prod_q <= {{(WIDTH-1){1'b0}}, as_d};
          state_q <= FIN;
        end
        ITER: begin
          prod_q <= op_q[0] ? div_d : mul_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= ALU;
        end
        FIN: begin
          result_q <= op_q[1] ? prod_q : {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
          cout_q   <= ~op_q[1] & prod_q[WIDTH];
          ovr_q    <= ~op_q[1] & (op_q[0] ? (wa_q[M] != wb_q[M]) : (wa_q[M] == wb_q[M])) & (prod_q[M] != wa_q[M]);
          divz_q   <= (op_q == 2'b11) && (wb_q == '0);
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign A_OUT   = a_q;
  assign B_OUT   = b_q;
  assign result  = result_q;
  assign Cout    = cout_q;
  assign OVR     = ovr_q;
  assign DivZero = divz_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: table-driven and directed checks for au_seq
module tb_au_seq;
  localparam int W = 8;
  logic         CLK = 1'b0;
  logic         reset_n = 1'b0;
  logic         LoadA = 1'b0, LoadB = 1'b0, Start = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [W-1:0] BIT_Input = '0;
  logic [W-1:0] A_OUT, B_OUT;
  logic [2*W-1:0] result;
  logic         Cout, OVR, DivZero, Busy, Done;
  int n_chk = 0, n_fail = 0, lat;

  au_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .reset_n(reset_n), .LoadA(LoadA), .LoadB(LoadB), .Start(Start),
    .OP(OP), .BIT_Input(BIT_Input), .A_OUT(A_OUT), .B_OUT(B_OUT), .result(result),
    .Cout(Cout), .OVR(OVR), .DivZero(DivZero), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] res;
    logic           cout, ovr, divz;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input bit sel_b, input logic [W-1:0] v);
    @(negedge CLK);
    BIT_Input = v;
    if (sel_b) LoadB = 1'b1; else LoadA = 1'b1;
    @(negedge CLK);
    LoadA = 1'b0;
    LoadB = 1'b0;
    chk(sel_b ? "load_b" : "load_a", sel_b ? B_OUT : A_OUT, v);
  endtask

  task automatic start_op(input logic [1:0] op);
    @(negedge CLK);
    OP = op;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    lat = 0;
    chk("busy_after_start", Busy, 1);
  endtask

  task automatic wait_done();
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic finish_checks(input string tag, input vec_t v);
    chk($sformatf("%s latency", tag), lat, v.op[1] ? W + 2 : 2);
    chk($sformatf("%s result", tag), result, v.res);
    chk($sformatf("%s cout", tag), Cout, v.cout);
    chk($sformatf("%s ovr", tag), OVR, v.ovr);
    chk($sformatf("%s divzero", tag), DivZero, v.divz);
    chk($sformatf("%s busy_at_done", tag), Busy, 0);
    @(negedge CLK);
    chk($sformatf("%s done_pulse", tag), Done, 0);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    load(0, v.a);
    load(1, v.b);
    start_op(v.op);
    wait_done();
    finish_checks(tag, v);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{2'b00, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 8'h05, 8'h07, 16'h00FE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'h80, 8'h01, 16'h007F, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{2'b00, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 8'h2A, 8'h00, 16'h2AFF, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2'b00, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b11, 8'hFF, 8'h10, 16'h0F0F, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge CLK);
    chk("rst A_OUT", A_OUT, 0);
    chk("rst B_OUT", B_OUT, 0);
    chk("rst result", result, 0);
    chk("rst flags", {Cout, OVR, DivZero, Busy, Done}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Mul FF*FF with a stray Start and LoadB arriving at edge k+3
    load(0, 8'hFF);
    load(1, 8'hFF);
    start_op(2'b10);
    @(negedge CLK); lat++;
    @(negedge CLK); lat++;
    Start = 1'b1; OP = 2'b00; LoadB = 1'b1; BIT_Input = 8'h33;
    @(negedge CLK); lat++;
    Start = 1'b0; LoadB = 1'b0;
    chk("mul B_OUT locked", B_OUT, 8'hFF);
    chk("mul busy mid", Busy, 1);
    wait_done();
    v = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0};
    finish_checks("mul_ffff", v);
    repeat (4) @(negedge CLK);
    chk("stray start ignored", Done, 0);

    // LoadA held high while data changes: only the first value is taken
    @(negedge CLK);
    LoadA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      BIT_Input = 8'h11 + 8'(i);
      @(negedge CLK);
    end
    LoadA = 1'b0;
    chk("held LoadA", A_OUT, 8'h11);

    // Reset during ITER cycle 4 of a multiply
    load(1, 8'h09);
    start_op(2'b10);
    repeat (3) @(negedge CLK);
    reset_n = 1'b0;
    #1;
    chk("abort A_OUT", A_OUT, 0);
    chk("abort B_OUT", B_OUT, 0);
    chk("abort result", result, 0);
    chk("abort flags", {Cout, OVR, DivZero, Busy, Done}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (i == 11) chk("abort no done", {Done, Busy}, 0);
    end
    reset_n = 1'b1;
    v = '{2'b00, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0, 1'b0};
    run_op("post_reset_add", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
